// File: rtl/clk_gate_ctrl.sv
// Request/acknowledge sequencer for the EN pin of one integrated clock gate.
// Optional wake-event statistic counter built when CLK_GATE_CTRL_STAT_EN is defined.
module clk_gate_ctrl #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WAKE_CYC = 4,
    parameter int unsigned IDLE_CYC = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               force_on,
    output logic [NUM_REQ-1:0] ack,
    output logic               gate_en,
    output logic [1:0]         state,
    output logic [15:0]        wake_cnt
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               gate_en_q;
    logic               any_req;

    assign any_req = (|req) | force_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            ack_q     <= '0;
            gate_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            gate_en_q <= (state_d != ST_OFF);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        unique case (state_q)
            ST_OFF: begin
                if (any_req) begin
                    state_d = ST_WAKE;
                    cnt_d   = '0;
                end
            end
            ST_WAKE: begin
                // A request dropped mid-wake still completes the settle time.
                if (cnt_q == WAKE_LAST) begin
                    cnt_d = '0;
                    if (any_req) begin
                        state_d = ST_ON;
                        ack_d   = req;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_ON: begin
                if (any_req) begin
                    ack_d = req;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                // A returning request takes priority over the terminal count.
                if (any_req) begin
                    state_d = ST_ON;
                    ack_d   = req;
                    cnt_d   = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef CLK_GATE_CTRL_STAT_EN
    logic [15:0] wake_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wake_cnt_q <= '0;
        end else if (state_q == ST_OFF && any_req && wake_cnt_q != '1) begin
            wake_cnt_q <= wake_cnt_q + 16'd1;
        end
    end

    assign wake_cnt = wake_cnt_q;
`else
    assign wake_cnt = '0;
`endif

    assign ack     = ack_q;
    assign gate_en = gate_en_q;
    assign state   = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed self-checking bench for clk_gate_ctrl (NUM_REQ=4, WAKE_CYC=4, IDLE_CYC=8).
// Observed tuple per check: {state[1:0], gate_en, ack[3:0]}.
module tb_clk_gate_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic        force_on;
    logic [3:0]  ack;
    logic        gate_en;
    logic [1:0]  state;
    logic [15:0] wake_cnt;

    int vectors;
    int errors;

    clk_gate_ctrl #(
        .NUM_REQ (4),
        .WAKE_CYC(4),
        .IDLE_CYC(8),
        .CNT_W   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .force_on(force_on),
        .ack     (ack),
        .gate_en (gate_en),
        .state   (state),
        .wake_cnt(wake_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_off();
        int n;
        req      = '0;
        force_on = 1'b0;
        n = 0;
        while (state !== 2'd0 && n < 40) begin
            step();
            n++;
        end
        vectors++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL go_off_timeout: state got %0d want 0", state);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        req      = 4'b1111;
        force_on = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if ({state, gate_en, ack} !== {2'd0, 1'b0, 4'b0000}) begin
                errors++;
                $display("FAIL reset_%0d: got %b want %b", i, {state, gate_en, ack}, {2'd0, 1'b0, 4'b0000});
            end
            vectors++;
            if (wake_cnt !== 16'd0) begin
                errors++;
                $display("FAIL reset_wake_cnt: got %h want 0000", wake_cnt);
            end
        end
        rst = 1'b0;
        step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd1, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL reset_release_wake: got %b want %b", {state, gate_en, ack}, {2'd1, 1'b1, 4'b0000});
        end
        go_off();
    endtask

    task automatic test_wake_latency();
        req = 4'b0001;
        step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd1, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL wake_e0: got %b want %b", {state, gate_en, ack}, {2'd1, 1'b1, 4'b0000});
        end
        for (int i = 1; i < 4; i++) begin
            step();
            vectors++;
            if ({state, gate_en, ack} !== {2'd1, 1'b1, 4'b0000}) begin
                errors++;
                $display("FAIL wake_e%0d: got %b want %b", i, {state, gate_en, ack}, {2'd1, 1'b1, 4'b0000});
            end
        end
        step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd2, 1'b1, 4'b0001}) begin
            errors++;
            $display("FAIL wake_e4_on: got %b want %b", {state, gate_en, ack}, {2'd2, 1'b1, 4'b0001});
        end
    endtask

    // Entered in ON with req[0] held.
    task automatic test_idle_hysteresis();
        req = 4'b0000;
        step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd3, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL idle_f0: got %b want %b", {state, gate_en, ack}, {2'd3, 1'b1, 4'b0000});
        end
        for (int i = 1; i < 8; i++) begin
            step();
            vectors++;
            if ({state, gate_en, ack} !== {2'd3, 1'b1, 4'b0000}) begin
                errors++;
                $display("FAIL idle_f%0d: got %b want %b", i, {state, gate_en, ack}, {2'd3, 1'b1, 4'b0000});
            end
        end
        step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd0, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL idle_f8_off: got %b want %b", {state, gate_en, ack}, {2'd0, 1'b0, 4'b0000});
        end
        // Request on the edge right after reaching OFF starts a new wake.
        req = 4'b0001;
        step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd1, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL off_rewake: got %b want %b", {state, gate_en, ack}, {2'd1, 1'b1, 4'b0000});
        end
        go_off();
    endtask

    task automatic test_wake_abort();
        req = 4'b0100;
        step();
        req = 4'b0000;
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd1, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL abort_still_wake: got %b want %b", {state, gate_en, ack}, {2'd1, 1'b1, 4'b0000});
        end
        step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd3, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL abort_to_idle: got %b want %b", {state, gate_en, ack}, {2'd3, 1'b1, 4'b0000});
        end
        go_off();
    endtask

    task automatic test_rerequest_idle();
        req = 4'b0001;
        for (int i = 0; i < 5; i++) step();
        req = 4'b0000;
        step();
        for (int i = 0; i < 5; i++) step();
        req = 4'b0100;
        step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd2, 1'b1, 4'b0100}) begin
            errors++;
            $display("FAIL reidle_cnt5: got %b want %b", {state, gate_en, ack}, {2'd2, 1'b1, 4'b0100});
        end
        req = 4'b0110;
        step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd2, 1'b1, 4'b0110}) begin
            errors++;
            $display("FAIL second_req_ack: got %b want %b", {state, gate_en, ack}, {2'd2, 1'b1, 4'b0110});
        end
        req = 4'b0010;
        step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd2, 1'b1, 4'b0010}) begin
            errors++;
            $display("FAIL drop_one_req: got %b want %b", {state, gate_en, ack}, {2'd2, 1'b1, 4'b0010});
        end
        // Request on the terminal idle count wins over turning off.
        req = 4'b0000;
        step();
        for (int i = 0; i < 7; i++) step();
        req = 4'b1000;
        step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd2, 1'b1, 4'b1000}) begin
            errors++;
            $display("FAIL reidle_terminal: got %b want %b", {state, gate_en, ack}, {2'd2, 1'b1, 4'b1000});
        end
        go_off();
    endtask

    task automatic test_force_on();
        force_on = 1'b1;
        req      = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if ({state, gate_en, ack} !== {2'd1, 1'b1, 4'b0000}) begin
                errors++;
                $display("FAIL force_wake_%0d: got %b want %b", i, {state, gate_en, ack}, {2'd1, 1'b1, 4'b0000});
            end
        end
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if ({state, gate_en, ack} !== {2'd2, 1'b1, 4'b0000}) begin
                errors++;
                $display("FAIL force_on_hold_%0d: got %b want %b", i, {state, gate_en, ack}, {2'd2, 1'b1, 4'b0000});
            end
        end
        force_on = 1'b0;
        step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd3, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL force_release_idle: got %b want %b", {state, gate_en, ack}, {2'd3, 1'b1, 4'b0000});
        end
        for (int i = 0; i < 7; i++) step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd3, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL force_idle_f7: got %b want %b", {state, gate_en, ack}, {2'd3, 1'b1, 4'b0000});
        end
        step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd0, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL force_idle_off: got %b want %b", {state, gate_en, ack}, {2'd0, 1'b0, 4'b0000});
        end
    endtask

    task automatic test_reset_mid_wake();
        req = 4'b0001;
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd1, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL midwake_pre: got %b want %b", {state, gate_en, ack}, {2'd1, 1'b1, 4'b0000});
        end
        rst = 1'b1;
        step();
        vectors++;
        if ({state, gate_en, ack} !== {2'd0, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL midwake_reset: got %b want %b", {state, gate_en, ack}, {2'd0, 1'b0, 4'b0000});
        end
        rst = 1'b0;
        req = 4'b0000;
        step();
    endtask

    task automatic full_cycle();
        req = 4'b0001;
        for (int i = 0; i < 5; i++) step();
        go_off();
    endtask

    task automatic test_stats();
`ifdef CLK_GATE_CTRL_STAT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) full_cycle();
        vectors++;
        if (wake_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stats_three: got %h want 0003", wake_cnt);
        end
        force dut.wake_cnt_q = 16'hFFFE;
        step();
        release dut.wake_cnt_q;
        for (int i = 0; i < 2; i++) full_cycle();
        vectors++;
        if (wake_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats_saturate: got %h want ffff", wake_cnt);
        end
`else
        req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (wake_cnt !== 16'd0) begin
                errors++;
                $display("FAIL stats_tied_%0d: got %h want 0000", i, wake_cnt);
            end
        end
        go_off();
        vectors++;
        if (wake_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stats_tied_off: got %h want 0000", wake_cnt);
        end
`endif
    endtask

    initial begin
        vectors  = 0;
        errors   = 0;
        rst      = 1'b1;
        req      = '0;
        force_on = 1'b0;
        test_reset();
        test_wake_latency();
        test_idle_hysteresis();
        test_wake_abort();
        test_rerequest_idle();
        test_force_on();
        test_reset_mid_wake();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
